ram_sync_clr: RTL and testbench

RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_sync_core.sv | 44 ++++
 rtl/ram_sync_clr.sv | 119 +++++++++++
 tb/tb_ram_sync_clr.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared types and default constants for the clearable sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Default geometry and clear value used by ram_sync_clr
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_CLR_VAL = 0;

    // Controller state: normal access or memory sweep in progress
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_sync_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_core
// Brief    : 1W1R memory array, synchronous write, registered read that holds
//            its value when no read is issued.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Array contents are never reset; the owner initialises them by sweeping
    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; old word is returned on a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_clr
// Brief    : Synchronous RAM with a hardware clear sweep after reset or on a
//            clr pulse. User writes/reads are blocked while the sweep runs.
//            Optional macro RAM_SYNC_CLR_FWD_EN forwards write data to a
//            same-address read in the same cycle (otherwise read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(DEF_CLR_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept_wr;
    logic              accept_rd;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    // User accesses only pass in IDLE and lose to a simultaneous clr
    always_comb begin
        accept_wr  = (state == IDLE) && !clr && we;
        accept_rd  = (state == IDLE) && !clr && re;
        core_we    = (state == CLEAR) || accept_wr;
        core_waddr = (state == CLEAR) ? cnt : waddr;
        core_wdata = (state == CLEAR) ? CLR_VAL : wdata;
    end

    // Controller: sweep counter, busy flag and read-valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            busy   <= 1'b1;
            cnt    <= '0;
            rvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rvalid <= accept_rd;
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    rvalid <= 1'b0;
                    cnt    <= cnt + 1'b1;
                    // Last word written this cycle; counter wraps back to 0
                    if (&cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy   <= 1'b1;
                    cnt    <= '0;
                    rvalid <= 1'b0;
                end
            endcase
        end
    end

    ram_sync_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (accept_rd),
        .raddr (raddr),
        .rdata (core_rdata)
    );

`ifdef RAM_SYNC_CLR_FWD_EN
    logic              fwd_sel;
    logic [DATA_W-1:0] fwd_data;

    // Capture a same-address write alongside each accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel  <= 1'b0;
            fwd_data <= '0;
        end else if (accept_rd) begin
            fwd_sel  <= accept_wr && (waddr == raddr);
            fwd_data <= wdata;
        end
    end

    assign rdata = fwd_sel ? fwd_data : core_rdata;
`else
    assign rdata = core_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sync_clr
// Brief    : Self-checking bench for ram_sync_clr: behavioural model compared
//            every cycle, directed scenarios with literal expectations, and a
//            randomized access phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sync_clr;

`ifdef RAM_SYNC_CLR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       busy;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic       rvalid;

    int checks = 0;
    int passes = 0;
    bit done   = 1'b0;

    ram_sync_clr dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .busy   (busy),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mem_m [DEPTH];
    bit         m_busy;
    int         m_left;
    int         m_pos;
    bit         m_rvalid;
    logic [7:0] m_rdata;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Behavioural model: sweep of DEPTH cycles, then plain RAM semantics
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b1;
            m_left   = DEPTH;
            m_pos    = 0;
            m_rvalid = 1'b0;
            m_rdata  = 8'h00;
        end else if (m_busy) begin
            mem_m[m_pos] = 8'h00;
            m_pos        = m_pos + 1;
            m_left       = m_left - 1;
            m_rvalid     = 1'b0;
            if (m_left == 0) m_busy = 1'b0;
        end else if (clr) begin
            m_busy   = 1'b1;
            m_left   = DEPTH;
            m_pos    = 0;
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = re;
            if (re) m_rdata = (FWD && we && waddr == raddr) ? wdata : mem_m[raddr];
            if (we) mem_m[waddr] = wdata;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (!done) begin
            check("busy", busy, m_busy);
            check("rvalid", rvalid, m_rvalid);
            check("rdata", rdata, m_rdata);
        end
    end

    task automatic step(input logic c, input logic w, input logic [3:0] wa, input logic [7:0] wd,
                        input logic r, input logic [3:0] ra);
        clr = c; we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
        @(posedge clk);
        #1;
        clr = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy) return;
            idle();
        end
        check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    // Count cycles busy stays high, starting from the current sample
    task automatic count_busy(output int k);
        k = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (busy) k++;
            else break;
        end
    endtask

    task automatic read_expect(input string name, input logic [3:0] a, input logic [7:0] exp);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, a);
        check({name, "_rvalid"}, rvalid, 1'b1);
        check(name, rdata, exp);
    endtask

    int k;

    initial begin
        clr = 0; we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_busy", busy, 1'b1);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_rdata", rdata, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Automatic sweep after reset lasts exactly DEPTH cycles
        k = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            k++;
            if (!busy) break;
        end
        check("busy_len_after_reset", k, 16);

        // Back-to-back reads of the cleared memory
        for (int i = 0; i < DEPTH; i++) read_expect("cleared_word", 4'(i), 8'h00);

        // Write then read next cycle
        step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
        read_expect("wr_then_rd", 4'd3, 8'hA5);

        // Same-address write and read in one cycle
        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        check("same_addr_rvalid", rvalid, 1'b1);
        check("same_addr_rdata", rdata, FWD ? 8'h3C : 8'h00);
        idle();
        check("hold_rvalid", rvalid, 1'b0);
        check("hold_rdata", rdata, FWD ? 8'h3C : 8'h00);
        read_expect("same_addr_later", 4'd7, 8'h3C);

        // Different-address simultaneous write and read
        step(1'b0, 1'b1, 4'd8, 8'h81, 1'b1, 4'd3);
        check("diff_addr_rdata", rdata, 8'hA5);
        read_expect("diff_addr_wr", 4'd8, 8'h81);

        // clr wins over a write in the same cycle
        step(1'b1, 1'b1, 4'd2, 8'h55, 1'b0, 4'd0);
        wait_idle();
        read_expect("clr_beats_we", 4'd2, 8'h00);

        // Fill with 0xFF, clear, re-pulse clr mid-sweep
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'(i), 8'hFF, 1'b0, 4'd0);
        read_expect("filled", 4'd5, 8'hFF);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        k = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin
                step(1'b1, 1'b1, 4'd1, 8'h12, 1'b1, 4'd3);
                check("re_during_busy", rvalid, 1'b0);
            end else begin
                idle();
            end
            if (busy) k++;
            else break;
        end
        check("busy_len_reclr", k, 16);
        for (int i = 0; i < DEPTH; i++) read_expect("reclr_word", 4'(i), 8'h00);

        // Reset in the middle of a sweep
        step(1'b0, 1'b1, 4'd9, 8'h77, 1'b0, 4'd0);
        read_expect("pre_reset", 4'd9, 8'h77);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        repeat (7) idle();
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_rdata", rdata, 8'h00);
        check("midsweep_rst_rvalid", rvalid, 1'b0);
        check("midsweep_rst_busy", busy, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            k++;
            if (!busy) break;
        end
        check("busy_len_after_midrst", k, 16);
        read_expect("post_rst_word", 4'd9, 8'h00);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
                 1'($urandom), 4'($urandom));
        end
        wait_idle();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
        idle();

        done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
